// File: rtl/vend_change_dispenser_if.sv
// rtl/vend_change_dispenser_if.sv - hopper eject handshake between dispenser and coin hopper
// One coin per hop_fire pulse; the hopper answers with hop_done once the coin is out.
interface vend_change_dispenser_if;
  logic       hop_fire;
  logic [2:0] hop_sel;
  logic       hop_done;

  modport master (output hop_fire, output hop_sel, input hop_done);
  modport slave  (input hop_fire, input hop_sel, output hop_done);
endinterface

// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - greedy change payout over a shared coin hopper
// Optional hopper acknowledge timeout: VEND_HOPPER_TIMEOUT_EN.
module vend_change_dispenser #(
  parameter int AMT_W    = 16,
  parameter int CNT_W    = 8,
  parameter int INIT_CNT = 20
`ifdef VEND_HOPPER_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 255
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    change_req,
  input  logic [AMT_W-1:0]        change_amt,
  input  logic                    restock_valid,
  input  logic [2:0]              restock_coin,
  input  logic [CNT_W-1:0]        restock_qty,
  vend_change_dispenser_if.master hop,
  output logic                    busy,
  output logic                    done,
  output logic [AMT_W-1:0]        shortfall,
  output logic                    fault
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FIRE, S_WAIT_ACK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic [2:0]       sel_q, sel_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  logic             pick_found;
  logic [2:0]       pick_code;
  logic             ack;
  logic             timeout_hit;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] code);
    case (code)
      3'd1:    coin_value = AMT_W'(5);
      3'd2:    coin_value = AMT_W'(10);
      3'd3:    coin_value = AMT_W'(50);
      3'd4:    coin_value = AMT_W'(100);
      3'd5:    coin_value = AMT_W'(500);
      default: coin_value = '0;
    endcase
  endfunction

  // Largest denomination first; an empty or oversized coin is skipped.
  always_comb begin
    pick_found = 1'b0;
    pick_code  = 3'd0;
    for (int i = 5; i >= 1; i--) begin
      if (!pick_found && cnt_q[i-1] != '0 && coin_value(3'(i)) <= rem_q) begin
        pick_found = 1'b1;
        pick_code  = 3'(i);
      end
    end
  end

  assign ack = (state_q == S_WAIT_ACK) && hop.hop_done;

`ifdef VEND_HOPPER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;

  assign timeout_hit = (state_q == S_WAIT_ACK) && !hop.hop_done &&
                       (wait_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT_ACK && !ack && !timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    short_d = short_q;
    sel_d   = sel_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (change_req) begin
          rem_d   = change_amt;
          short_d = '0;
          fault_d = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (pick_found) begin
          sel_d   = pick_code;
          state_d = S_FIRE;
        end else begin
          short_d = rem_q;
          state_d = S_DONE;
        end
      end
      S_FIRE: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack) begin
          rem_d   = rem_q - coin_value(sel_q);
          state_d = S_SELECT;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          short_d = rem_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A restock aimed at the coin being decremented this cycle is dropped.
  always_comb begin
    logic [CNT_W:0] sum;
    for (int i = 0; i < 5; i++) begin
      sum      = {1'b0, cnt_q[i]} + {1'b0, restock_qty};
      cnt_d[i] = cnt_q[i];
      if (ack && sel_q == 3'(i + 1)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end else if (restock_valid && restock_coin == 3'(i + 1)) begin
        cnt_d[i] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      short_q <= '0;
      sel_q   <= 3'd0;
      fault_q <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= CNT_W'(INIT_CNT);
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      short_q <= short_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign hop.hop_fire = (state_q == S_FIRE);
  assign hop.hop_sel  = (state_q == S_FIRE) ? sel_q : 3'd0;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign shortfall    = short_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// tb/tb_vend_change_dispenser.sv - randomized bench for vend_change_dispenser against a greedy payout model
// Covers the timeout path only when VEND_HOPPER_TIMEOUT_EN is defined.
module tb_vend_change_dispenser;
  logic        clk;
  logic        reset;
  logic        change_req;
  logic [15:0] change_amt;
  logic        restock_valid;
  logic [2:0]  restock_coin;
  logic [7:0]  restock_qty;
  logic        busy;
  logic        done;
  logic [15:0] shortfall;
  logic        fault;

  int checks;
  int failures;
  int inv [1:5];

  vend_change_dispenser_if hop_if ();

  vend_change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .change_req    (change_req),
    .change_amt    (change_amt),
    .restock_valid (restock_valid),
    .restock_coin  (restock_coin),
    .restock_qty   (restock_qty),
    .hop           (hop_if.master),
    .busy          (busy),
    .done          (done),
    .shortfall     (shortfall),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_val(input int c);
    case (c)
      1: return 5;
      2: return 10;
      3: return 50;
      4: return 100;
      5: return 500;
      default: return 0;
    endcase
  endfunction

  function automatic void model_restock(input int code, input int qty);
    if (code >= 1 && code <= 5) inv[code] = (inv[code] + qty > 255) ? 255 : inv[code] + qty;
  endfunction

  task automatic check_counts(input string tag);
    logic [7:0] v;
    for (int c = 1; c <= 5; c++) begin
      v = dut.cnt_q[c-1];
      check_eq($sformatf("%s cnt[%0d]", tag, c), {24'd0, v}, inv[c]);
    end
  endtask

  task automatic do_restock(input int code, input int qty);
    @(negedge clk);
    restock_valid = 1'b1;
    restock_coin  = 3'(code);
    restock_qty   = 8'(qty);
    @(negedge clk);
    restock_valid = 1'b0;
    model_restock(code, qty);
  endtask

  // Greedy payout computed from the inventory model, then compared to the hopper traffic.
  task automatic run_payout(input string tag, input int amt, input int dly,
                            input bit with_rs, input int rs_code, input int rs_qty,
                            output int n_fires);
    int  exp_q[$];
    int  obs_q[$];
    int  rem, done_cyc, wcnt, sf;
    bit  found, got_done, waiting;
    if (with_rs) model_restock(rs_code, rs_qty);
    rem = amt;
    do begin
      found = 1'b0;
      for (int c = 5; c >= 1; c--) begin
        if (!found && inv[c] > 0 && coin_val(c) <= rem) begin
          found = 1'b1;
          exp_q.push_back(c);
          rem -= coin_val(c);
          inv[c]--;
        end
      end
    end while (found);

    @(negedge clk);
    change_req    = 1'b1;
    change_amt    = 16'(amt);
    restock_valid = with_rs;
    restock_coin  = 3'(rs_code);
    restock_qty   = 8'(rs_qty);
    got_done = 1'b0; waiting = 1'b0; wcnt = 0; done_cyc = 0; sf = 0;
    for (int cyc = 1; cyc <= 3000 && !got_done; cyc++) begin
      @(negedge clk);
      change_req    = (cyc == 2);
      change_amt    = (cyc == 2) ? 16'd777 : change_amt;
      restock_valid = 1'b0;
      hop_if.hop_done = 1'b0;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        sf       = int'(shortfall);
        check_eq({tag, " busy_at_done"}, {31'd0, busy}, 1);
      end else if (hop_if.hop_fire) begin
        obs_q.push_back(int'(hop_if.hop_sel));
        waiting = 1'b1;
        wcnt    = dly;
      end else if (waiting) begin
        if (wcnt == 0) begin
          hop_if.hop_done = 1'b1;
          waiting = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end
    change_req = 1'b0;
    check_eq({tag, " done_seen"}, {31'd0, got_done}, 1);
    check_eq({tag, " fires"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s sel[%0d]", tag, i), (i < obs_q.size()) ? obs_q[i] : 0, exp_q[i]);
    check_eq({tag, " shortfall"}, sf, rem);
    check_eq({tag, " latency"}, done_cyc, exp_q.size() * (3 + dly) + 2);
    check_eq({tag, " fault"}, {31'd0, fault}, 0);
    @(negedge clk);
    check_eq({tag, " idle_after"}, {30'd0, busy, done}, 0);
    check_counts(tag);
    n_fires = obs_q.size();
  endtask

  initial begin
    int nf;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    change_req = 1'b0;
    change_amt = '0;
    restock_valid = 1'b0;
    restock_coin = '0;
    restock_qty = '0;
    hop_if.hop_done = 1'b0;
    for (int c = 1; c <= 5; c++) inv[c] = 20;
    repeat (2) @(negedge clk);
    check_eq("reset outs", {busy, done, fault, hop_if.hop_fire, hop_if.hop_sel}, 0);
    check_eq("reset shortfall", {16'd0, shortfall}, 0);
    check_counts("reset");
    reset = 1'b0;

    run_payout("T1", 165, 2, 1'b0, 0, 0, nf);
    check_eq("T1 cnt100", {24'd0, dut.cnt_q[3]}, 19);
    run_payout("T2", 7, 1, 1'b0, 0, 0, nf);
    run_payout("T3", 0, 0, 1'b0, 0, 0, nf);

    for (int k = 0; k < 10 && inv[4] > 0; k++) run_payout("T4drain", 400, 0, 1'b0, 0, 0, nf);
    do_restock(4, 0);
    run_payout("T4", 200, 0, 1'b0, 0, 0, nf);
    check_eq("T4 four_fifties", nf, 4);

    do_restock(5, 250);
    check_eq("T7 sat", {24'd0, dut.cnt_q[4]}, 255);

    // Reset while waiting for the hopper
    @(negedge clk);
    change_req = 1'b1;
    change_amt = 16'd5;
    @(negedge clk);
    change_req = 1'b0;
    for (int k = 0; k < 20 && !hop_if.hop_fire; k++) @(negedge clk);
    check_eq("T6 fired", {31'd0, hop_if.hop_fire}, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("T6 busy_done", {30'd0, busy, done}, 0);
    for (int c = 1; c <= 5; c++) inv[c] = 20;
    check_counts("T6");
    @(negedge clk);
    reset = 1'b0;
    run_payout("T6 after", 5, 0, 1'b0, 0, 0, nf);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0)
        do_restock(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      run_payout($sformatf("R%0d", it), int'($urandom_range(0, 1500)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 40)), nf);
    end

`ifdef VEND_HOPPER_TIMEOUT_EN
    begin
      bit gd;
      gd = 1'b0;
      @(negedge clk);
      change_req = 1'b1;
      change_amt = 16'd10;
      @(negedge clk);
      change_req = 1'b0;
      for (int k = 0; k < 2000 && !gd; k++) begin
        if (done) gd = 1'b1;
        else @(negedge clk);
      end
      check_eq("T5 done", {31'd0, gd}, 1);
      check_eq("T5 fault", {31'd0, fault}, 1);
      check_eq("T5 shortfall", {16'd0, shortfall}, 10);
      @(negedge clk);
      check_counts("T5");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
